// File: rtl/seq_for_pkg.sv
// Shared definitions for the sequential generate-for accumulator.
// Provides the FSM state encoding, the default parameter values and the
// step-counter width helper used by seq_for_accum.
package seq_for_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam int unsigned DEF_NBITS  = 8;
  localparam int unsigned DEF_COUNT  = 4;
  localparam int          DEF_INIT   = 1;
  localparam int          DEF_OFFSET = 17;

  // Width of a counter covering steps 0 .. 2*count-1, never narrower than 1.
  function automatic int unsigned step_width(input int unsigned count);
    int unsigned w;
    w = $clog2(2 * count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_for_accum_if.sv
// Operand/result handshake bundle for seq_for_accum.
//   a, b    : operands (NBITS, unsigned), sampled on accept
//   mode    : 0 = alternate A+B / A-B, 1 = A+B every step
//   start   : input valid          ready  : input ready (IDLE only)
//   xout    : result (NBITS)       xvalid : result valid (HOLD only)
//   xready  : result consumer ready
// master = producer/consumer side, slave = accumulator side.
interface seq_for_accum_if
  import seq_for_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS
) ();

  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             mode;
  logic             start;
  logic             ready;
  logic [NBITS-1:0] xout;
  logic             xvalid;
  logic             xready;

  modport master (
    output a, b, mode, start, xready,
    input  ready, xout, xvalid
  );

  modport slave (
    input  a, b, mode, start, xready,
    output ready, xout, xvalid
  );

endinterface

// File: rtl/seq_for_step.sv
// One accumulation step: acc_next = acc + term, where term is a+b when
// mode is set or the step index is even, and a-b otherwise.
//   acc, a, b : NBITS inputs     mode, step_lsb : step selection
//   acc_next  : NBITS output, modulo 2^NBITS
module seq_for_step
  import seq_for_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS
) (
  input  logic [NBITS-1:0] acc,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             mode,
  input  logic             step_lsb,
  output logic [NBITS-1:0] acc_next
);

  logic [NBITS-1:0] term;

  always_comb begin
    term     = (mode || !step_lsb) ? (a + b) : (a - b);
    acc_next = acc + term;
  end

endmodule

// File: rtl/seq_for_accum.sv
// Sequential generate-for accumulator. Accepts (A, B, MODE) in IDLE, runs
// 2*COUNT accumulation steps from INIT, then holds XOUT = acc - OFFSET with
// XVALID until the consumer takes it.
//   clk, rst : clock and synchronous active-high reset
//   bus      : seq_for_accum_if.slave handshake bundle
module seq_for_accum
  import seq_for_pkg::*;
#(
  parameter int unsigned NBITS  = DEF_NBITS,
  parameter int unsigned COUNT  = DEF_COUNT,
  parameter int          INIT   = DEF_INIT,
  parameter int          OFFSET = DEF_OFFSET
) (
  input logic           clk,
  input logic           rst,
  seq_for_accum_if.slave bus
);

  localparam int unsigned SW = step_width(COUNT);
  localparam logic [NBITS-1:0] INIT_V   = NBITS'(INIT);
  localparam logic [NBITS-1:0] OFFSET_V = NBITS'(OFFSET);
  localparam logic [SW-1:0]    LAST     = SW'(2 * COUNT - 1);

  state_t           state;
  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;
  logic             mode_q;
  logic [NBITS-1:0] acc;
  logic [NBITS-1:0] acc_next;
  logic [NBITS-1:0] xout_q;
  logic [SW-1:0]    step;

  seq_for_step #(
    .NBITS(NBITS)
  ) u_step (
    .acc      (acc),
    .a        (a_q),
    .b        (b_q),
    .mode     (mode_q),
    .step_lsb (step[0]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      acc    <= '0;
      step   <= '0;
      xout_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mode_q <= bus.mode;
            acc    <= INIT_V;
            step   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          step <= step + SW'(1);
          // Final step: the result is taken from the step output directly,
          // so acc never needs an extra cycle to settle.
          if (step == LAST) begin
            xout_q <= acc_next - OFFSET_V;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (bus.xready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.xvalid = (state == HOLD);
  assign bus.xout   = xout_q;

endmodule

// File: tb/tb_seq_for_accum.sv
module tb_seq_for_accum;

  localparam int unsigned NBITS  = 8;
  localparam int unsigned COUNT  = 4;
  localparam int          INIT   = 1;
  localparam int          OFFSET = 17;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  logic [NBITS-1:0] sb[$];

  seq_for_accum_if #(.NBITS(NBITS)) bus ();

  seq_for_accum #(
    .NBITS (NBITS),
    .COUNT (COUNT),
    .INIT  (INIT),
    .OFFSET(OFFSET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [NBITS-1:0] model(input logic [NBITS-1:0] a,
                                             input logic [NBITS-1:0] b,
                                             input logic mode);
    logic [NBITS-1:0] acc;
    acc = NBITS'(INIT);
    for (int unsigned i = 0; i < 2 * COUNT; i++) begin
      if (mode || (i % 2 == 0)) acc = acc + a + b;
      else                      acc = acc + a - b;
    end
    return acc - NBITS'(OFFSET);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input string tag, input logic [NBITS-1:0] a,
                        input logic [NBITS-1:0] b, input logic mode,
                        input logic [NBITS-1:0] expv);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " ready before accept"}, 32'(bus.ready), 32'd1);
    bus.a = a; bus.b = b; bus.mode = mode; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    sb.push_back(expv);
    // Operands are latched; scramble the inputs to prove it.
    bus.a = NBITS'($urandom); bus.b = NBITS'($urandom); bus.mode = 1'($urandom);
    chk({tag, " ready after accept"}, 32'(bus.ready), 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int n;
    logic [NBITS-1:0] e;
    n = 0;
    while (bus.xvalid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(2 * COUNT));
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    chk({tag, " xout"}, 32'(bus.xout), 32'(e));
  endtask

  task automatic consume(input string tag);
    bus.xready = 1'b1;
    @(posedge clk); #1;
    bus.xready = 1'b0;
    chk({tag, " ready after take"}, 32'(bus.ready), 32'd1);
    chk({tag, " xvalid after take"}, 32'(bus.xvalid), 32'd0);
  endtask

  initial begin
    logic [NBITS-1:0] held;
    logic [NBITS-1:0] dummy;
    int acc1;
    total = 0;
    bad   = 0;
    bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.start = 1'b0; bus.xready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset ready", 32'(bus.ready), 32'd1);
    chk("reset xvalid", 32'(bus.xvalid), 32'd0);
    chk("reset xout", 32'(bus.xout), 32'd0);

    accept("alt", 8'd3, 8'd1, 1'b0, 8'd8);
    wait_result("alt");
    consume("alt");

    accept("sum", 8'd3, 8'd1, 1'b1, 8'd16);
    wait_result("sum");
    consume("sum");

    accept("wrap alt", 8'd200, 8'd100, 1'b0, 8'd48);
    wait_result("wrap alt");
    consume("wrap alt");

    accept("wrap sum", 8'd200, 8'd100, 1'b1, 8'd80);
    wait_result("wrap sum");
    consume("wrap sum");

    // Abort in flight at step 3; the queued expectation is discarded.
    accept("abort", 8'd55, 8'd21, 1'b0, model(8'd55, 8'd21, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dummy = sb.pop_back();
    chk("abort ready", 32'(bus.ready), 32'd1);
    chk("abort xvalid", 32'(bus.xvalid), 32'd0);
    chk("abort xout", 32'(bus.xout), 32'd0);
    chk("abort stays idle", 32'(bus.ready), 32'd1);

    accept("post reset", 8'd9, 8'd5, 1'b0, model(8'd9, 8'd5, 1'b0));
    wait_result("post reset");

    // Back-pressure: hold 5 cycles with START pulses that must be ignored.
    held = bus.xout;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.a = NBITS'($urandom);
      bus.b = NBITS'($urandom);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("bp xvalid", 32'(bus.xvalid), 32'd1);
      chk("bp xout", 32'(bus.xout), 32'(held));
      chk("bp ready", 32'(bus.ready), 32'd0);
    end
    consume("bp");
    @(posedge clk); #1;
    chk("bp idle", 32'(bus.ready), 32'd1);

    // Back-to-back with START and XREADY held high throughout.
    bus.a = 8'd17; bus.b = 8'd40; bus.mode = 1'b0;
    bus.start = 1'b1; bus.xready = 1'b1;
    @(posedge clk); #1;
    acc1 = cyc;
    sb.push_back(model(8'd17, 8'd40, 1'b0));
    bus.a = 8'd123; bus.b = 8'd77; bus.mode = 1'b1;
    wait_result("b2b first");
    @(posedge clk); #1;
    chk("b2b ready after take", 32'(bus.ready), 32'd1);
    chk("b2b xvalid after take", 32'(bus.xvalid), 32'd0);
    @(posedge clk); #1;
    sb.push_back(model(8'd123, 8'd77, 1'b1));
    chk("b2b second accept", 32'(bus.ready), 32'd0);
    chk("b2b spacing", 32'(cyc - acc1), 32'(2 * COUNT + 2));
    bus.start = 1'b0;
    bus.xready = 1'b0;
    wait_result("b2b second");
    consume("b2b second");

    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
